spi_master: RTL and testbench

Host-side SPI master that drives the team's SPI slave / single-port RAM subsystem from the system clock. It accepts one 10-bit command word per transaction from a local host, serialises it MSB-first on MOSI under ss_n framing, and for read-data commands captures the 8-bit response on MISO and returns it to the host. It sits between the host/test controller and the SPI slave. The ss_n, MOSI and MISO pins connect directly to the slave's same-named ports. clk is shared with the slave.

---
 rtl/spi_master.sv | 96 +++++++++
 tb/tb_spi_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: serialises one 10-bit {cmd, din} word per transaction on MOSI under ss_n framing
// and, for read-data commands, captures the 8-bit MISO response into rd_data.
module spi_master #(
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] din,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       ss_n,
    output logic       MOSI,
    input  logic       MISO
);
    typedef enum logic [2:0] {IDLE, SEL, SHIFT, PAD, WAIT, CAPTURE, GAP} state_t;
    localparam logic [3:0] LAT_END = 4'(RD_LAT > 0 ? RD_LAT - 1 : 0);
    state_t     state;
    logic [9:0] sr;
    logic [3:0] cnt;
    logic       rd_cmd;
    assign cmd_ready = rst_n && state == IDLE;
    // Outputs are assigned for the state being entered, so each pin is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            rd_cmd   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            ss_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    state  <= SEL;
                    sr     <= {cmd, din};
                    rd_cmd <= &cmd;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    ss_n   <= 1'b0;
                    MOSI   <= cmd[1];
                end
                SEL: if (cnt == 4'd1) begin
                    state <= SHIFT;
                    cnt   <= '0;
                    MOSI  <= sr[9];
                    sr    <= {sr[8:0], 1'b0};
                end else cnt <= cnt + 4'd1;
                SHIFT: if (cnt == 4'd9) begin
                    state <= PAD;
                    cnt   <= '0;
                    MOSI  <= 1'b0;
                end else begin
                    cnt  <= cnt + 4'd1;
                    MOSI <= sr[9];
                    sr   <= {sr[8:0], 1'b0};
                end
                PAD: begin
                    cnt <= '0;
                    if (!rd_cmd) begin
                        state <= GAP;
                        ss_n  <= 1'b1;
                    end else state <= (RD_LAT == 0) ? CAPTURE : WAIT;
                end
                WAIT: if (cnt == LAT_END) begin
                    state <= CAPTURE;
                    cnt   <= '0;
                end else cnt <= cnt + 4'd1;
                // The emptied shift register collects MISO; rd_data is only touched on the last sample.
                CAPTURE: begin
                    sr <= {sr[8:0], MISO};
                    if (cnt == 4'd7) begin
                        state    <= GAP;
                        cnt      <= '0;
                        rd_data  <= {sr[6:0], MISO};
                        rd_valid <= 1'b1;
                        ss_n     <= 1'b1;
                    end else cnt <= cnt + 4'd1;
                end
                GAP: if (cnt == 4'd1) begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else cnt <= cnt + 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master framing, read capture, blocking and reset behaviour.
module tb_spi_master;
    localparam int RD_LAT = 2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = '0;
    logic [7:0] din = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       ss_n;
    logic       MOSI;
    logic       MISO = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [63:0] ss_tr, mosi_tr, rv_tr, rdy_tr, busy_tr;
    logic [7:0]  rd_tr [64];

    spi_master #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .din(din), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Records cycles T0..T(n-1) starting at the negedge of T0; plays byte b on MISO in the capture window.
    task automatic trace(input int n, input logic [7:0] b, input logic jitter);
        ss_tr = '0; mosi_tr = '0; rv_tr = '0; rdy_tr = '0; busy_tr = '0;
        for (int t = 0; t < n; t++) begin
            ss_tr[t] = ss_n; mosi_tr[t] = MOSI; rv_tr[t] = rd_valid;
            rdy_tr[t] = cmd_ready; busy_tr[t] = busy; rd_tr[t] = rd_data;
            MISO = (t >= 13 + RD_LAT && t <= 20 + RD_LAT) ? b[20 + RD_LAT - t] : 1'($urandom);
            if (jitter) din = 8'($urandom);
            @(negedge clk);
        end
    endtask

    // Raises cmd_valid, waits for acceptance, returns positioned at the negedge of T0.
    task automatic accept(input logic [1:0] c, input logic [7:0] d, input logic hold);
        int k = 0;
        cmd = c; din = d; cmd_valid = 1'b1;
        while (!cmd_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL accept_timeout cmd=%0d cmd_ready=%b required=1", c, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = hold;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b1; cmd = 2'b11; din = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ss_n, MOSI, cmd_ready, busy, rd_valid, rd_data} !== {5'b10000, 8'h00}) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got ss_n=%b mosi=%b rdy=%b busy=%b rv=%b rd=%h required 1 0 0 0 0 00",
                         i, ss_n, MOSI, cmd_ready, busy, rd_valid, rd_data);
            end
        end
        cmd_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, ss_n, busy} !== 3'b110) begin
            failures++;
            $display("FAIL reset_release got rdy=%b ss_n=%b busy=%b required 1 1 0", cmd_ready, ss_n, busy);
        end
    endtask

    task automatic test_write_addr();
        accept(2'b00, 8'hA5, 1'b0);
        trace(16, 8'h00, 1'b0);
        checks++;
        if (mosi_tr[15:0] !== 16'h0A50) begin
            failures++;
            $display("FAIL wr_addr_mosi got=%h required=0a50", mosi_tr[15:0]);
        end
        checks++;
        if (ss_tr[15:0] !== 16'hE000) begin
            failures++;
            $display("FAIL wr_addr_ss got=%h required=e000", ss_tr[15:0]);
        end
        checks++;
        if (rv_tr[15:0] !== 16'h0000) begin
            failures++;
            $display("FAIL wr_addr_rd_valid got=%h required=0000", rv_tr[15:0]);
        end
        checks++;
        if ({rdy_tr[15:0], busy_tr[15:0]} !== {16'h8000, 16'h7FFF}) begin
            failures++;
            $display("FAIL wr_addr_ready_busy got rdy=%h busy=%h required 8000 7fff", rdy_tr[15:0], busy_tr[15:0]);
        end
    endtask

    task automatic test_read_data();
        accept(2'b11, 8'h00, 1'b0);
        trace(26, 8'hB2, 1'b0);
        checks++;
        if (mosi_tr[25:0] !== 26'h000000F) begin
            failures++;
            $display("FAIL rd_mosi got=%h required=000000f", mosi_tr[25:0]);
        end
        checks++;
        if (ss_tr[25:0] !== 26'h3800000) begin
            failures++;
            $display("FAIL rd_ss got=%h required=3800000", ss_tr[25:0]);
        end
        checks++;
        if (rv_tr[25:0] !== 26'h0800000) begin
            failures++;
            $display("FAIL rd_valid_pulse got=%h required=0800000", rv_tr[25:0]);
        end
        checks++;
        if ({rd_tr[22], rd_tr[23]} !== {8'h00, 8'hB2}) begin
            failures++;
            $display("FAIL rd_data got T22=%h T23=%h required 00 b2", rd_tr[22], rd_tr[23]);
        end
        checks++;
        if ({rdy_tr[25:0], busy_tr[25:0]} !== {26'h2000000, 26'h1FFFFFF}) begin
            failures++;
            $display("FAIL rd_ready_busy got rdy=%h busy=%h required 2000000 1ffffff", rdy_tr[25:0], busy_tr[25:0]);
        end
    endtask

    // Slave+RAM model decodes each frame from MOSI and serves read data from its own memory.
    task automatic test_ram_sequence();
        logic [1:0] cs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] ds [4] = '{8'h10, 8'h3C, 8'h10, 8'h00};
        logic [7:0] ram [256];
        logic [7:0] addr = '0;
        logic [9:0] w;
        int n, g;
        for (int a = 0; a < 256; a++) ram[a] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            n = (cs[i] == 2'b11) ? 26 : 16;
            accept(cs[i], ds[i], 1'b0);
            trace(n, ram[addr], 1'b0);
            for (int k = 0; k < 10; k++) w[9 - k] = mosi_tr[2 + k];
            checks++;
            if (w !== {cs[i], ds[i]}) begin
                failures++;
                $display("FAIL ram_frame%0d_word got=%h required=%h", i, w, {cs[i], ds[i]});
            end
            case (w[9:8])
                2'b00, 2'b10: addr = w[7:0];
                2'b01: ram[addr] = w[7:0];
                default: ;
            endcase
            g = 0;
            for (int t = n - 1; t >= 0 && ss_tr[t]; t--) g++;
            checks++;
            if (g < 2) begin
                failures++;
                $display("FAIL ram_frame%0d_gap got=%0d required>=2", i, g);
            end
            if (i == 0) begin
                checks++;
                if (rd_tr[15] !== 8'hB2) begin
                    failures++;
                    $display("FAIL ram_rd_data_hold got=%h required=b2", rd_tr[15]);
                end
            end
        end
        checks++;
        if ({rv_tr[23], rd_tr[23]} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL ram_readback got rv=%b rd=%h required 1 3c", rv_tr[23], rd_tr[23]);
        end
    endtask

    task automatic test_back_to_back();
        accept(2'b01, 8'hC3, 1'b1);
        trace(15, 8'h00, 1'b1);
        checks++;
        if (mosi_tr[14:0] !== 15'h0C38) begin
            failures++;
            $display("FAIL b2b_frame1_mosi got=%h required=0c38", mosi_tr[14:0]);
        end
        checks++;
        if ({rdy_tr[14:0], busy_tr[14:0]} !== {15'h0000, 15'h7FFF}) begin
            failures++;
            $display("FAIL b2b_blocked got rdy=%h busy=%h required 0000 7fff", rdy_tr[14:0], busy_tr[14:0]);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_idle got rdy=%b required=1", cmd_ready);
        end
        cmd = 2'b10; din = 8'h5A;
        @(negedge clk);
        cmd_valid = 1'b0;
        trace(15, 8'h00, 1'b0);
        checks++;
        if ({busy_tr[0], ss_tr[0]} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b ss_n=%b required 1 0", busy_tr[0], ss_tr[0]);
        end
        checks++;
        if (mosi_tr[14:0] !== 15'h05A7) begin
            failures++;
            $display("FAIL b2b_frame2_mosi got=%h required=05a7", mosi_tr[14:0]);
        end
    endtask

    task automatic test_mid_reset();
        int rv = 0;
        int sl = 0;
        accept(2'b11, 8'h00, 1'b0);
        trace(6, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ss_n, MOSI, cmd_ready, busy, rd_valid, rd_data} !== {5'b10000, 8'h00}) begin
            failures++;
            $display("FAIL midreset_outputs got ss_n=%b mosi=%b rdy=%b busy=%b rv=%b rd=%h required 1 0 0 0 0 00",
                     ss_n, MOSI, cmd_ready, busy, rd_valid, rd_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rd_valid) rv++;
            if (!ss_n) sl++;
            @(negedge clk);
        end
        checks++;
        if (rv != 0 || sl != 0) begin
            failures++;
            $display("FAIL midreset_quiet got rv_cycles=%0d ss_low_cycles=%0d required 0 0", rv, sl);
        end
        accept(2'b11, 8'h00, 1'b0);
        trace(26, 8'h6D, 1'b0);
        checks++;
        if ({rv_tr[25:0], rd_tr[22], rd_tr[23]} !== {26'h0800000, 8'h00, 8'h6D}) begin
            failures++;
            $display("FAIL midreset_recover got rv=%h T22=%h T23=%h required 0800000 00 6d",
                     rv_tr[25:0], rd_tr[22], rd_tr[23]);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_read_data();
        test_ram_sequence();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
